// File: rtl/lift_pkg.sv
// Shared types and constants for the lift cabin-motion controller.
//   Direction encodings from the direction arbiter, FSM state enum,
//   lowest floor number, and a helper that sizes the step timer.
package lift_pkg;

    typedef enum logic [1:0] {
        DIR_STOP   = 2'b00,
        DIR_DOWN   = 2'b01,
        DIR_UP     = 2'b10,
        DIR_UPDOWN = 2'b11
    } lift_dir_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_ESTOP = 3'd3,
        ST_FAULT = 3'd4
    } lift_state_e;

    localparam int unsigned FLOOR_FIRST = 1;

    // clog2 of the longer interval, never narrower than one bit.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter for move/hold intervals.
//   clk, reset : clock, asynchronous active-high reset
//   en_i       : decrement enable (stops at zero)
//   load_i     : load value_i, overrides en_i
//   value_i    : value to load
//   zero_o     : registered, high while the count is zero
module lift_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             zero_q;

    // Next count: load wins, otherwise saturating decrement.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/lift_motion_ctrl.sv
// Cabin-motion controller: steps the cabin one floor per command, then
// holds/settles; emergency stop and sticky fault on illegal commands.
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : advances FSM and timer; freezes both when low
//   doorOpen          : door not fully closed
//   estop             : emergency stop, level-sensitive
//   currentFloor      : settled cabin floor (1..NUM_FLOORS)
//   currentDirection  : STOP/DOWN/UP/UPDOWN from the direction arbiter
//   nextFloor         : step destination; follows currentFloor when idle
//   move              : cabin in motion
//   arrived           : one-cycle strobe at the end of a move
//   fault             : sticky illegal-command flag, cleared by reset only
module lift_motion_ctrl
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = 7,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned CLK_PER_MOVE = 10,
    parameter int unsigned CLK_PER_HOLD = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               doorOpen,
    input  logic               estop,
    input  logic [FLOOR_W-1:0] currentFloor,
    input  logic [1:0]         currentDirection,
    output logic [FLOOR_W-1:0] nextFloor,
    output logic               move,
    output logic               arrived,
    output logic               fault
);

    localparam int unsigned        TMR_W     = tmr_width(CLK_PER_MOVE, CLK_PER_HOLD);
    localparam logic [TMR_W-1:0]   MOVE_LOAD = TMR_W'(CLK_PER_MOVE - 1);
    localparam logic [TMR_W-1:0]   HOLD_LOAD = TMR_W'(CLK_PER_HOLD - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR = FLOOR_W'(FLOOR_FIRST);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);

    lift_state_e        state_q, state_d;
    logic [FLOOR_W-1:0] next_floor_q, next_floor_d;
    logic               move_q, move_d;
    logic               arrived_q, arrived_d;
    logic               fault_q, fault_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_value;
    logic               tmr_zero;

    lift_dir_e          dir;
    logic               floor_ok;
    logic               can_up;
    logic               can_down;
    logic               abort;

    assign dir      = lift_dir_e'(currentDirection);
    assign floor_ok = (currentFloor >= BOT_FLOOR) && (currentFloor <= TOP_FLOOR);
    assign can_up   = floor_ok && (currentFloor < TOP_FLOOR);
    assign can_down = floor_ok && (currentFloor > BOT_FLOOR);
    // Emergency stop preempts everything except FAULT and an existing ESTOP.
    assign abort    = estop && (state_q inside {ST_IDLE, ST_MOVE, ST_HOLD});

    lift_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .en_i    (enable),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            next_floor_q <= BOT_FLOOR;
            move_q       <= 1'b0;
            arrived_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_floor_q <= next_floor_d;
            move_q       <= move_d;
            arrived_q    <= arrived_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_ESTOP;
        end else if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (doorOpen) begin
                        state_d = ST_HOLD;
                    end else begin
                        case (dir)
                            DIR_STOP: state_d = ST_IDLE;
                            DIR_UP:   state_d = can_up   ? ST_MOVE : ST_FAULT;
                            DIR_DOWN: state_d = can_down ? ST_MOVE : ST_FAULT;
                            default:  state_d = ST_FAULT;
                        endcase
                    end
                end
                ST_MOVE:  if (tmr_zero) state_d = ST_HOLD;
                ST_HOLD:  if (tmr_zero && !doorOpen) state_d = ST_IDLE;
                ST_ESTOP: if (!estop) state_d = ST_HOLD;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output and timer-control logic.
    always_comb begin
        // Destination is latched only while moving; otherwise track the cabin.
        next_floor_d = move_q ? next_floor_q : currentFloor;
        move_d       = move_q;
        arrived_d    = 1'b0;
        fault_d      = fault_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        if (abort) begin
            move_d       = 1'b0;
            next_floor_d = currentFloor;
            tmr_load     = 1'b1;
        end else if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_MOVE) begin
                        move_d       = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_value    = MOVE_LOAD;
                        next_floor_d = (dir == DIR_UP) ? currentFloor + FLOOR_W'(1)
                                                       : currentFloor - FLOOR_W'(1);
                    end else if (state_d == ST_HOLD) begin
                        tmr_load  = 1'b1;
                        tmr_value = HOLD_LOAD;
                    end else if (state_d == ST_FAULT) begin
                        fault_d = 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (state_d == ST_HOLD) begin
                        move_d    = 1'b0;
                        arrived_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_value = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    // Door still open at expiry: settle for another interval.
                    if (tmr_zero && doorOpen) begin
                        tmr_load  = 1'b1;
                        tmr_value = HOLD_LOAD;
                    end
                end
                ST_ESTOP: begin
                    if (state_d == ST_HOLD) begin
                        tmr_load  = 1'b1;
                        tmr_value = HOLD_LOAD;
                    end
                end
                ST_FAULT: begin
                    fault_d      = 1'b1;
                    move_d       = 1'b0;
                    next_floor_d = currentFloor;
                end
                default: ;
            endcase
        end
    end

    assign nextFloor = next_floor_q;
    assign move      = move_q;
    assign arrived   = arrived_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Directed bench for lift_motion_ctrl: a 7-floor instance (move 4, hold 3)
// and a 15-floor instance (move 2, hold 2) share clock and reset.
module tb_lift_motion_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       a_en, a_door, a_estop;
    logic [2:0] a_cf;
    logic [1:0] a_dir;
    logic [2:0] a_nf;
    logic       a_move, a_arr, a_fault;

    logic       b_en, b_door, b_estop;
    logic [3:0] b_cf;
    logic [1:0] b_dir;
    logic [3:0] b_nf;
    logic       b_move, b_arr, b_fault;

    int n_cmp = 0;
    int n_err = 0;

    lift_motion_ctrl #(
        .NUM_FLOORS   (7),
        .FLOOR_W      (3),
        .CLK_PER_MOVE (4),
        .CLK_PER_HOLD (3)
    ) u_dut_a (
        .clk              (clk),
        .reset            (reset),
        .enable           (a_en),
        .doorOpen         (a_door),
        .estop            (a_estop),
        .currentFloor     (a_cf),
        .currentDirection (a_dir),
        .nextFloor        (a_nf),
        .move             (a_move),
        .arrived          (a_arr),
        .fault            (a_fault)
    );

    lift_motion_ctrl #(
        .NUM_FLOORS   (15),
        .FLOOR_W      (4),
        .CLK_PER_MOVE (2),
        .CLK_PER_HOLD (2)
    ) u_dut_b (
        .clk              (clk),
        .reset            (reset),
        .enable           (b_en),
        .doorOpen         (b_door),
        .estop            (b_estop),
        .currentFloor     (b_cf),
        .currentDirection (b_dir),
        .nextFloor        (b_nf),
        .move             (b_move),
        .arrived          (b_arr),
        .fault            (b_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expect move low for 'zeros' edges on instance A, then high.
    task automatic move_after(input string tag, input int zeros);
        for (int i = 0; i < zeros; i++) begin
            tick();
            check(tag, 32'(a_move), 0);
        end
        tick();
        check(tag, 32'(a_move), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   cnt;
        logic arr_seen;
        logic seen;

        reset   = 1'b1;
        a_en    = 1'b1; a_door = 1'b0; a_estop = 1'b0; a_cf = 3'd3; a_dir = 2'b00;
        b_en    = 1'b1; b_door = 1'b0; b_estop = 1'b0; b_cf = 4'd1; b_dir = 2'b00;
        #2;
        check("rst_nf",    32'(a_nf), 1);
        check("rst_move",  32'(a_move), 0);
        check("rst_arr",   32'(a_arr), 0);
        check("rst_fault", 32'(a_fault), 0);

        tick();
        reset = 1'b0;
        tick();
        check("idle_follow", 32'(a_nf), 3);

        // UP from floor 3: move for 4 cycles, arrive, hold 3, idle.
        a_dir = 2'b10;
        tick();
        check("up_nf",   32'(a_nf), 4);
        check("up_move", 32'(a_move), 1);
        a_dir = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("up_moving", 32'(a_move), 1);
            check("up_no_arr", 32'(a_arr), 0);
        end
        tick();
        check("up_end_move", 32'(a_move), 0);
        check("up_arr",      32'(a_arr), 1);
        check("up_end_nf",   32'(a_nf), 4);
        a_cf  = 3'd4;
        a_dir = 2'b10;
        tick();
        check("arr_one_cycle", 32'(a_arr), 0);
        move_after("hold_len", 2);
        check("up2_nf", 32'(a_nf), 5);

        // Estop on the 2nd cycle of a move.
        tick();
        check("es_pre_move", 32'(a_move), 1);
        a_estop = 1'b1;
        a_dir   = 2'b00;
        tick();
        check("es_move", 32'(a_move), 0);
        check("es_arr",  32'(a_arr), 0);
        check("es_nf",   32'(a_nf), 4);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("es_stay_move", 32'(a_move), 0);
            check("es_stay_arr",  32'(a_arr), 0);
        end
        a_estop = 1'b0;
        a_dir   = 2'b10;
        move_after("es_hold", 4);
        check("es_up_nf", 32'(a_nf), 5);

        // Enable low for 5 cycles mid-move stretches move to 9 cycles.
        a_dir    = 2'b00;
        cnt      = 1;
        arr_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            a_en = !(i >= 1 && i <= 5);
            tick();
            if (a_move) begin
                cnt++;
            end else begin
                arr_seen = a_arr;
                break;
            end
        end
        a_en = 1'b1;
        check("en_move_len", 32'(cnt), 9);
        check("en_arr",      32'(arr_seen), 1);

        // Door open across hold expiries: no move; closing lets UP proceed.
        a_cf   = 3'd5;
        a_door = 1'b1;
        a_dir  = 2'b10;
        seen   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= a_move;
        end
        check("door_hold", 32'(seen), 0);
        a_door = 1'b0;
        move_after("door_close", 2);
        check("door_nf", 32'(a_nf), 6);

        // Asynchronous reset mid-move.
        #2;
        reset = 1'b1;
        #1;
        check("arst_move", 32'(a_move), 0);
        check("arst_nf",   32'(a_nf), 1);

        // DOWN at floor 1 -> sticky fault.
        a_cf  = 3'd1;
        a_dir = 2'b01;
        tick();
        reset = 1'b0;
        tick();
        check("flt_set",  32'(a_fault), 1);
        check("flt_move", 32'(a_move), 0);
        a_estop = 1'b1; a_dir = 2'b10; a_cf = 3'd3; a_door = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flt_sticky", 32'(a_fault), 1);
        end
        check("flt_nf",     32'(a_nf), 3);
        check("flt_move2",  32'(a_move), 0);
        reset = 1'b1;
        #1;
        check("flt_clear", 32'(a_fault), 0);
        a_estop = 1'b0; a_door = 1'b0; a_dir = 2'b00;

        // UPDOWN is illegal.
        tick();
        reset = 1'b0;
        a_cf  = 3'd2;
        a_dir = 2'b11;
        tick();
        check("updown_flt", 32'(a_fault), 1);

        // Instance B: estop coinciding with timer expiry wins.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b_cf  = 4'd14;
        b_dir = 2'b10;
        tick();
        check("b_es_start", 32'(b_move), 1);
        b_dir = 2'b00;
        tick();
        check("b_es_last", 32'(b_move), 1);
        b_estop = 1'b1;
        tick();
        check("b_es_move", 32'(b_move), 0);
        check("b_es_arr",  32'(b_arr), 0);
        b_estop = 1'b0;

        // Instance B: UP at 14 reaches 15; UP at 15 faults.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b_cf  = 4'd14;
        b_dir = 2'b10;
        tick();
        check("b_up_nf",   32'(b_nf), 15);
        check("b_up_move", 32'(b_move), 1);
        tick(2);
        check("b_arr",     32'(b_arr), 1);
        b_cf = 4'd15;
        tick();
        check("b_hold1", 32'(b_fault), 0);
        tick();
        check("b_hold2", 32'(b_fault), 0);
        tick();
        check("b_top_flt", 32'(b_fault), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
